alu_pipe: RTL



---
 rtl/alu_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides: carry-chained
// add/sub, shift-add multiplier (low/high half) and variable shifts/rotates.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             overflow,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             smaller,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0]   a_r, b_r;
  logic               hi_r;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic               cflag;

  logic               accept, mul_in, arith_in, mul_done, keep;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     ea, eb, sum;
  logic [2*WIDTH-1:0] dbl, rr, rl;
  logic [WIDTH-1:0]   res, mul_res;
  logic               co, ov;

  assign mul_in    = (ALU_Sel == 4'b0010) || (ALU_Sel == 4'b0110);
  // 0000/0001/0100/0101 are the only opcodes that feed the carry chain
  assign arith_in  = !ALU_Sel[3] && !ALU_Sel[1];
  assign keep      = (ALU_Sel != 4'b0111);
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == MUL);
  assign out_valid = (state == HOLD);
  assign mul_done  = busy && (cnt == SHW'(WIDTH-1));
  assign acc_nx    = acc + (b_r[cnt] ? ({{WIDTH{1'b0}}, a_r} << cnt) : '0);
  assign mul_res   = hi_r ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];

  always_comb begin
    ea  = {1'b0, A};
    eb  = {1'b0, B};
    sh  = SHW'({1'b0, B[SHW-1:0]} % (SHW+1)'(WIDTH));
    dbl = {A, A};
    rr  = dbl >> sh;
    rl  = dbl << sh;
    sum = '0;
    res = '0;
    co  = 1'b0;
    ov  = 1'b0;
    case (ALU_Sel)
      4'b0000, 4'b0100: begin
        sum = ea + eb + {{WIDTH{1'b0}}, cflag & ALU_Sel[2]};
        res = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (A[WIDTH-1] == B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0001, 4'b0101: begin
        sum = ea - eb - {{WIDTH{1'b0}}, cflag & ALU_Sel[2]};
        res = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (A[WIDTH-1] != B[WIDTH-1]) && (res[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0011: begin
        sum = {1'b0, ~B} + (WIDTH+1)'(1);
        res = sum[WIDTH-1:0];
        co  = sum[WIDTH];
        ov  = (B == MSB_ONLY);
      end
      4'b1000: res = A & B;
      4'b1001: res = A ^ B;
      4'b1010: res = A | B;
      4'b1011: res = ~B;
      4'b1100: res = A >> sh;
      4'b1101: res = A << sh;
      4'b1110: res = rr[WIDTH-1:0];
      4'b1111: res = rl[2*WIDTH-1:WIDTH];
      default: res = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = mul_in ? MUL : HOLD;
      MUL:     if (mul_done) state_nx = HOLD;
      HOLD:    if (out_ready) state_nx = !in_valid ? IDLE : (mul_in ? MUL : HOLD);
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      hi_r     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      cflag    <= 1'b0;
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      equal    <= 1'b0;
      greater  <= 1'b0;
      smaller  <= 1'b0;
    end else if (accept) begin
      a_r  <= A;
      b_r  <= B;
      hi_r <= ALU_Sel[2];
      if (mul_in) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        ALU_Out  <= res;
        CarryOut <= co;
        overflow <= ov;
        zero     <= keep && (res == '0);
        equal    <= keep && (A == B);
        greater  <= keep && (A > B);
        smaller  <= keep && (A < B);
        if (arith_in) cflag <= co;
      end
    end else if (busy) begin
      acc <= acc_nx;
      cnt <= cnt + SHW'(1);
      if (mul_done) begin
        ALU_Out  <= mul_res;
        CarryOut <= 1'b0;
        overflow <= 1'b0;
        zero     <= (mul_res == '0);
        equal    <= (a_r == b_r);
        greater  <= (a_r > b_r);
        smaller  <= (a_r < b_r);
      end
    end
  end
endmodule
